// File: rtl/tnew_track_if.sv
// Bundle of D-stage issue inputs and E/M/W hazard outputs of tnew_track.
// The master side drives D; the slave side is the tracker.
interface tnew_track_if #(
  parameter int TW = 32
);
  logic          stop;
  logic          flush;
  logic [4:0]    D_A1;
  logic [4:0]    D_A2;
  logic [4:0]    D_A3;
  logic [TW-1:0] D_Tnew;
  logic [1:0]    D_md_start;
  logic          D_use_md;
  logic [4:0]    E_A3;
  logic [4:0]    M_A3;
  logic [4:0]    W_A3;
  logic [TW-1:0] E_Tnew;
  logic [TW-1:0] M_Tnew;
  logic [TW-1:0] W_Tnew;
  logic [1:0]    fwd_A1;
  logic [1:0]    fwd_A2;
  logic          md_busy;
  logic          md_stall;

  modport master (
    output stop, flush, D_A1, D_A2, D_A3, D_Tnew, D_md_start, D_use_md,
    input  E_A3, M_A3, W_A3, E_Tnew, M_Tnew, W_Tnew,
    input  fwd_A1, fwd_A2, md_busy, md_stall
  );

  modport slave (
    input  stop, flush, D_A1, D_A2, D_A3, D_Tnew, D_md_start, D_use_md,
    output E_A3, M_A3, W_A3, E_Tnew, M_Tnew, W_Tnew,
    output fwd_A1, fwd_A2, md_busy, md_stall
  );
endinterface

// File: rtl/tnew_track.sv
// Tnew/Tuse producer: carries A3/Tnew through E, M, W and derives forwarding selects.
// Define TNEW_TRACK_MDU_EN to add multiply/divide unit occupancy tracking.
module tnew_track #(
  parameter int TW       = 32,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  tnew_track_if.slave tif
);

  logic          bubble;
  logic [4:0]    a3_p0, a3_p1, a3_p2;
  logic [TW-1:0] tnew_p0, tnew_p1, tnew_p2;
  logic          vld_p0, vld_p1, vld_p2;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - {{(TW-1){1'b0}}, 1'b1};
  endfunction

  // The youngest stage writing src decides; if it is still producing, no older stage may be used.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0) begin
      if (vld_p0 && a3_p0 == src)      sel = (tnew_p0 == '0) ? 2'd1 : 2'd0;
      else if (vld_p1 && a3_p1 == src) sel = (tnew_p1 == '0) ? 2'd2 : 2'd0;
      else if (vld_p2 && a3_p2 == src) sel = (tnew_p2 == '0) ? 2'd3 : 2'd0;
    end
    return sel;
  endfunction

  assign bubble = tif.stop | tif.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_p0   <= '0;
      a3_p1   <= '0;
      a3_p2   <= '0;
      tnew_p0 <= '0;
      tnew_p1 <= '0;
      tnew_p2 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      // D -> E
      if (bubble) begin
        a3_p0   <= '0;
        tnew_p0 <= '0;
        vld_p0  <= 1'b0;
      end else begin
        a3_p0   <= tif.D_A3;
        tnew_p0 <= (tif.D_A3 != 5'd0) ? tif.D_Tnew : '0;
        vld_p0  <= (tif.D_A3 != 5'd0);
      end
      // E -> M
      a3_p1   <= a3_p0;
      tnew_p1 <= sat_dec(tnew_p0);
      vld_p1  <= vld_p0;
      // M -> W
      a3_p2   <= a3_p1;
      tnew_p2 <= sat_dec(tnew_p1);
      vld_p2  <= vld_p1;
    end
  end

  assign tif.E_A3   = a3_p0;
  assign tif.M_A3   = a3_p1;
  assign tif.W_A3   = a3_p2;
  assign tif.E_Tnew = tnew_p0;
  assign tif.M_Tnew = tnew_p1;
  assign tif.W_Tnew = tnew_p2;

  always_comb begin
    tif.fwd_A1 = fwd_sel(tif.D_A1);
    tif.fwd_A2 = fwd_sel(tif.D_A2);
  end

`ifdef TNEW_TRACK_MDU_EN
  localparam int CW = $clog2(DIV_CYC + 1);

  logic [1:0]    md_flag_p0;
  logic [CW-1:0] md_cnt;
  logic          md_busy_w;

  // The start flag sits in E for one edge, then loads the countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_flag_p0 <= 2'b00;
      md_cnt     <= '0;
    end else begin
      md_flag_p0 <= bubble ? 2'b00 : tif.D_md_start;
      if (md_flag_p0 == 2'b01)      md_cnt <= CW'(MULT_CYC);
      else if (md_flag_p0 == 2'b10) md_cnt <= CW'(DIV_CYC);
      else if (md_cnt != '0)        md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy_w    = (md_cnt != '0) || (md_flag_p0 == 2'b01) || (md_flag_p0 == 2'b10);
  assign tif.md_busy  = md_busy_w;
  assign tif.md_stall = tif.D_use_md & md_busy_w;
`else
  localparam int unused_cyc = MULT_CYC + DIV_CYC;
  logic unused_md;

  assign unused_md    = ^{tif.D_md_start, tif.D_use_md};
  assign tif.md_busy  = 1'b0;
  assign tif.md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_tnew_track.sv
// Randomized bench for tnew_track against an age-based model of in-flight instructions.
module tb_tnew_track;
  localparam int TW       = 32;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
`ifdef TNEW_TRACK_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  tnew_track_if #(.TW(TW)) tif ();

  tnew_track #(.TW(TW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  always #5 clk = ~clk;

  // Model: each entry is what entered E at some edge; its Tnew at age k is tn-k floored at 0.
  typedef struct {
    int       a3;
    int       tn;
    bit [1:0] md;
  } ent_t;

  ent_t q[$];
  int   edge_n = 0;
  int   busy_until = -1;

  function automatic void model_reset();
    ent_t z;
    z = '{a3: 0, tn: 0, md: 2'b00};
    q = {z, z, z};
    busy_until = -1;
  endfunction

  function automatic int exp_a3(int k);
    return q[k].a3;
  endfunction

  function automatic int exp_tn(int k);
    int t;
    t = q[k].tn - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int exp_fwd(int src);
    if (src == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (exp_a3(k) == src) return (exp_tn(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic bit exp_busy();
    return MDU && (edge_n <= busy_until);
  endfunction

  function automatic void model_edge();
    ent_t e;
    if (reset) return;
    edge_n++;
    if (tif.stop || tif.flush) e = '{a3: 0, tn: 0, md: 2'b00};
    else if (tif.D_A3 == 5'd0) e = '{a3: 0, tn: 0, md: tif.D_md_start};
    else e = '{a3: int'(tif.D_A3), tn: int'(tif.D_Tnew), md: tif.D_md_start};
    if (e.md == 2'b01) busy_until = edge_n + MULT_CYC;
    if (e.md == 2'b10) busy_until = edge_n + DIV_CYC;
    q.push_front(e);
    q.pop_back();
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("E_A3", tif.E_A3, exp_a3(0));
    chk("M_A3", tif.M_A3, exp_a3(1));
    chk("W_A3", tif.W_A3, exp_a3(2));
    chk("E_Tnew", tif.E_Tnew, exp_tn(0));
    chk("M_Tnew", tif.M_Tnew, exp_tn(1));
    chk("W_Tnew", tif.W_Tnew, exp_tn(2));
    chk("fwd_A1", tif.fwd_A1, exp_fwd(int'(tif.D_A1)));
    chk("fwd_A2", tif.fwd_A2, exp_fwd(int'(tif.D_A2)));
    chk("md_busy", tif.md_busy, exp_busy());
    chk("md_stall", tif.md_stall, tif.D_use_md & exp_busy());
  endtask

  // The integrator ORs md_stall into stop; the bench uses its own model for that.
  task automatic drive(input int a1, input int a2, input int a3, input int tn,
                       input bit [1:0] md, input bit umd, input bit st, input bit fl);
    tif.D_A1       = 5'(a1);
    tif.D_A2       = 5'(a2);
    tif.D_A3       = 5'(a3);
    tif.D_Tnew     = TW'(tn);
    tif.D_md_start = md;
    tif.D_use_md   = umd;
    tif.flush      = fl;
    tif.stop       = st | (umd & exp_busy());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int mdu_cnt;
  int r;

  initial begin
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_E_A3", tif.E_A3, 0);
    chk("rst_W_Tnew", tif.W_Tnew, 0);
    #1 reset = 1'b0;

    // lw-like producer observed by a D consumer of the same register
    drive(8, 0, 8, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lw_E_A3", tif.E_A3, 8);
    chk("lw_E_Tnew", tif.E_Tnew, 2);
    chk("lw_fwd1", tif.fwd_A1, 0);
    drive(8, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lw_M_A3", tif.M_A3, 8);
    chk("lw_M_Tnew", tif.M_Tnew, 1);
    chk("lw_fwd2", tif.fwd_A1, 0);
    tick();
    chk("lw_W_A3", tif.W_A3, 8);
    chk("lw_W_Tnew", tif.W_Tnew, 0);
    chk("lw_fwd3", tif.fwd_A1, 3);

    // ALU producer
    drive(0, 0, 9, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("alu_E", tif.E_Tnew, 1);
    drive(9, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 chk("alu_fwd_E", tif.fwd_A1, 0);
    tick();
    chk("alu_M_Tnew", tif.M_Tnew, 0);
    chk("alu_fwd_M", tif.fwd_A1, 2);

    // stop holds D while older entries drain
    drive(0, 0, 3, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 0, 7, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("stop1_E_A3", tif.E_A3, 0);
    chk("stop1_M_Tnew", tif.M_Tnew, 1);
    tick();
    chk("stop2_E_A3", tif.E_A3, 0);
    chk("stop2_W_A3", tif.W_A3, 3);
    chk("stop2_W_Tnew", tif.W_Tnew, 0);
    drive(0, 0, 7, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rel_E_A3", tif.E_A3, 7);
    chk("rel_E_Tnew", tif.E_Tnew, 1);

    // stop together with flush is a plain bubble
    drive(0, 0, 6, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    chk("sf_E_A3", tif.E_A3, 0);

    // zero destination never carries Tnew
    drive(0, 0, 0, 3, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("z_E_Tnew", tif.E_Tnew, 0);
    chk("z_fwd", tif.fwd_A1, 0);

    // same register in E and M: youngest wins
    drive(0, 0, 4, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(4, 4, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 chk("same_fwd1", tif.fwd_A1, 1);
    chk("same_fwd2", tif.fwd_A2, 1);

    // asynchronous reset with E(5,2) in flight
    drive(0, 0, 5, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_E_A3", tif.E_A3, 5);
    #2 reset = 1'b1;
    #1 model_reset();
    chk("arst_E_A3", tif.E_A3, 0);
    chk("arst_E_Tnew", tif.E_Tnew, 0);
    check_all();
    #1 reset = 1'b0;
    drive(5, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_E_A3", tif.E_A3, 0);

    // mult start, then an HI/LO reader waits for the MDU
    drive(0, 0, 0, 0, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    mdu_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 if (tif.md_stall) mdu_cnt++;
      tick();
    end
    chk("mdu_stall_cycles", mdu_cnt, MDU ? 1 + MULT_CYC : 0);

    // randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      bit [1:0] md;
      bit       umd;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        #1 reset = 1'b0;
      end
      r   = $urandom_range(0, 15);
      md  = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      umd = (md == 2'b01) || (md == 2'b10) || ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), md, umd,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      #1 check_all();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tnew_track.md
Name: tnew_track

Overview:
- Producer side of the Tnew/Tuse hazard protocol for the 5-stage pipeline.
- Carries each issued instruction's destination register (A3) and Tnew from D through E, M and W. Decrements Tnew as the instruction advances.
- Drives the E/M/W A3 and Tnew values that the stall controller consumes.
- Also derives forwarding-source selects for D's A1/A2, and optionally tracks multiply/divide unit occupancy.

Parameters:
- TW, 32, width of Tnew fields.
- MULT_CYC, 5, mult/multu busy cycles (MDU feature only).
- DIV_CYC, 10, div/divu busy cycles (MDU feature only).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stop  in  1  stall: D holds, bubble enters E
- flush  in  1  bubble enters E regardless of stop
- D_A1  in  5  D-stage source register 1
- D_A2  in  5  D-stage source register 2
- D_A3  in  5  D-stage destination register (0 = no write)
- D_Tnew  in  TW  Tnew the D instruction will carry on entering E
- D_md_start  in  2  01 = mult-class, 10 = div-class, 00/11 = none
- D_use_md  in  1  D instruction reads or writes HI/LO or starts the MDU
- E_A3, M_A3, W_A3  out  5  per-stage destination
- E_Tnew, M_Tnew, W_Tnew  out  TW  per-stage remaining Tnew
- fwd_A1  out  2  0 = regfile, 1 = E, 2 = M, 3 = W
- fwd_A2  out  2  same encoding as fwd_A1, for D_A2
- md_busy  out  1  MDU occupied
- md_stall  out  1  D_use_md & (md_busy | E holds an MDU start)

Behaviour:
- Reset: all A3 = 0, all Tnew = 0, MDU counter = 0, E MDU-start flag = 0.
- All outputs are therefore 0 during and after reset. Reset mid-operation discards every in-flight entry immediately; no clock is needed.
- Each rising edge updates stages as follows:
  - E: if flush or stop, E_A3 <= 0 and E_Tnew <= 0 (bubble). Otherwise E_A3 <= D_A3 and E_Tnew <= D_Tnew, except when D_A3 == 0, where E_Tnew <= 0.
  - M: M_A3 <= E_A3; M_Tnew <= E_Tnew - 1, saturating at 0.
  - W: W_A3 <= M_A3; W_Tnew <= M_Tnew - 1, saturating at 0.
- M and W always advance; stop only affects E entry. Latency from D to W is 3 edges.
- Invariant: any stage with A3 == 0 has Tnew == 0.
- fwd_A1 and fwd_A2 are combinational from registered state and D inputs:
  - Select the youngest stage X in priority E > M > W where X_A3 == D_Ax, X_A3 != 0 and X_Tnew == 0.
  - If the youngest matching stage has X_Tnew != 0, fwd = 0. The stall controller holds D in that case, and an older stage must not be selected.
  - D_Ax == 0 gives fwd = 0.
- Simultaneous stop and flush: behaves as a bubble, identical to either alone.

Optional Feature:
- Macro: TNEW_TRACK_MDU_EN.
- Defined: 2-bit E MDU-start flag and an MDU countdown of width clog2(DIV_CYC+1).
  - On a non-stalled, non-flushed E entry, the flag takes D_md_start. A bubble clears it.
  - Next edge with flag 01 loads the counter with MULT_CYC; flag 10 loads DIV_CYC.
  - Otherwise the counter decrements while nonzero.
  - md_busy = (counter != 0) | (flag == 01 or 10).
  - md_stall = D_use_md & md_busy. The integrator ORs md_stall into stop.
  - A load while the counter is nonzero cannot occur, because the starting instruction was held by md_stall.
- Undefined: md_busy = 0 and md_stall = 0 constantly. No counter or flag logic is synthesized.

Test Plan:
- Reset pulse mid-run with E_A3 = 5, E_Tnew = 2: outputs 0 asynchronously, before the next edge; stay 0 until fresh D entry.
- Issue lw-like D_A3 = 8, D_Tnew = 2, stop = 0: edge 1 gives E(8,2); edge 2 gives M(8,1); edge 3 gives W(8,0). fwd_A1 for D_A1 = 8 is 0, 0, 3 after edges 1, 2, 3.
- ALU op D_A3 = 9, D_Tnew = 1, then the next D_A1 = 9: E(9,1), fwd_A1 = 0. After one more edge M(9,0), fwd_A1 = 2.
- stop = 1 for 2 edges with D_A3 = 7, D_Tnew = 1: E_A3 = 0 both edges. Older M/W entries advance and decrement. Release stop: E(7,1).
- D_A3 = 0 with D_Tnew = 3: E(0,0); fwd_A1 with D_A1 = 0 is 0. Same-register case: E(4,0) and M(4,0) both present, D_A1 = 4 gives fwd_A1 = 1.
- TNEW_TRACK_MDU_EN: issue mult (01), then D_use_md = 1 next cycle. md_stall is high for 1 + MULT_CYC = 6 cycles, then low. With the macro undefined, md_stall stays 0.
